// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: scans a SPRITE_W x SPRITE_H box row-major, reading the char or background ROM and plotting pixels.
// Optional macro SPRITE_TRANSPARENCY_EN: character pixels equal to TRANSPARENT_COLOUR are not plotted.
module sprite_draw_engine #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COLOUR_W = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 9'h1FF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic [7:0]          char_addr,
  input  logic [COLOUR_W-1:0] char_data,
  output logic [16:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                doneBG,
  output logic                doneChar,
  output logic                busy,
  output logic [2:0]          fsm_state
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_BG   = 3'd1,
    RUN_CHAR = 3'd2,
    FLUSH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_next;

  logic          prev_bg, prev_char, pend_bg, pend_char;
  logic          rise_bg, rise_char, want_bg, want_char;
  logic          start_bg, start_char, running, draw_char;
  logic [8:0]    x_lat;
  logic [7:0]    y_lat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_pix;
  logic [9:0]    scr_x;
  logic [8:0]    scr_y;
  logic [16:0]   y17, pix_bg_addr;
  logic [7:0]    pix_char_addr;
  logic          in_bounds;
  logic          pipe_valid, pipe_char, pipe_in, keyed;

  // A request starts a draw only on its rising edge; edges that cannot start now are held pending.
  assign rise_bg   = drawBG & ~prev_bg;
  assign rise_char = drawChar & ~prev_char;
  assign want_bg   = pend_bg | rise_bg;
  assign want_char = pend_char | rise_char;

  assign last_pix = (col == CW'(SPRITE_W - 1)) && (row == RW'(SPRITE_H - 1));

  // Screen position is kept one bit wider than the screen so clipped pixels never wrap.
  assign scr_x         = {1'b0, x_lat} + 10'(col);
  assign scr_y         = {1'b0, y_lat} + 9'(row);
  assign y17           = 17'(scr_y);
  assign pix_bg_addr   = (y17 << 8) + (y17 << 6) + 17'(scr_x);
  assign pix_char_addr = 8'(row) * 8'(SPRITE_W) + 8'(col);
  assign in_bounds     = (scr_x < 10'd320) && (scr_y < 9'd240);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_bg   = 1'b0;
    start_char = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (want_bg) begin
          start_bg   = 1'b1;
          state_next = RUN_BG;
        end else if (want_char) begin
          start_char = 1'b1;
          state_next = RUN_CHAR;
        end else begin
          state_next = IDLE;
        end
      end
      RUN_BG, RUN_CHAR: if (last_pix) state_next = FLUSH;
      FLUSH:            state_next = DONE;
      default:          state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    running   = 1'b0;
    doneBG    = 1'b0;
    doneChar  = 1'b0;
    char_addr = '0;
    bg_addr   = '0;
    case (state)
      RUN_BG, RUN_CHAR: begin
        running   = 1'b1;
        char_addr = pix_char_addr;
        bg_addr   = pix_bg_addr;
      end
      DONE: begin
        doneBG   = ~draw_char;
        doneChar = draw_char;
      end
      default: ;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_bg   <= 1'b0;
      prev_char <= 1'b0;
      pend_bg   <= 1'b0;
      pend_char <= 1'b0;
      draw_char <= 1'b0;
      x_lat     <= '0;
      y_lat     <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      prev_bg   <= drawBG;
      prev_char <= drawChar;
      pend_bg   <= want_bg & ~start_bg;
      pend_char <= want_char & ~start_char;
      if (start_bg || start_char) begin
        x_lat     <= xCoordinate;
        y_lat     <= yCoordinate;
        draw_char <= start_char;
        col       <= '0;
        row       <= '0;
      end else if (running) begin
        if (col == CW'(SPRITE_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        col <= '0;
        row <= '0;
      end
    end
  end

  // Position and slot validity travel alongside the one-cycle ROM read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_valid <= 1'b0;
      pipe_char  <= 1'b0;
      pipe_in    <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
    end else begin
      pipe_valid <= running;
      pipe_char  <= draw_char;
      pipe_in    <= in_bounds;
      vga_x      <= scr_x[8:0];
      vga_y      <= scr_y[7:0];
    end
  end

  assign keyed      = KEY_EN && pipe_char && (char_data == TRANSPARENT_COLOUR);
  assign plot       = pipe_valid && pipe_in && !keyed;
  assign vga_colour = pipe_valid ? (pipe_char ? char_data : bg_data) : '0;

endmodule

// File: doc/sprite_draw_engine.md
SPRITE_DRAW_ENGINE -- requirements
Module: sprite_draw_engine

Interface
REQ-001 Parameter SPRITE_W, default 8, sprite width in pixels (SPRITE_W*SPRITE_H <= 256).
REQ-002 Parameter SPRITE_H, default 8, sprite height in pixels.
REQ-003 Parameter COLOUR_W, default 9, colour bits per pixel (3 per channel).
REQ-004 Parameter TRANSPARENT_COLOUR, default 9'h1FF, character key colour; used only under REQ-027.
REQ-005 Ports: clock in 1, the single clock; all logic on its rising edge.
REQ-006 Ports: resetn in 1; reset is asynchronous and active-low.
REQ-007 Ports: drawBG in 1, request to repaint background under the sprite box; drawChar in 1, request to draw the character.
REQ-008 Ports: xCoordinate in 9, yCoordinate in 8, sprite top-left screen position (320x240).
REQ-009 Ports: char_addr out 8, char_data in COLOUR_W, synchronous character ROM, 1-cycle read latency.
REQ-010 Ports: bg_addr out 17, bg_data in COLOUR_W, synchronous background ROM, 1-cycle read latency.
REQ-011 Ports: vga_x out 9, vga_y out 8, vga_colour out COLOUR_W, plot out 1, pixel write to the VGA adapter.
REQ-012 Ports: doneBG out 1, doneChar out 1, one-cycle completion pulses; busy out 1, high whenever state is not IDLE.

Function
REQ-013 States: IDLE, RUN_BG, RUN_CHAR, FLUSH, DONE.
REQ-014 Start: rising edge of a request (current high, previously sampled low); level-held requests never restart a draw.
REQ-015 On start, xCoordinate/yCoordinate are latched; later changes have no effect on the current draw.
REQ-016 Both request rising edges in the same cycle: BG drawn first; char request recorded pending and started from DONE without a new edge.
REQ-017 A char rising edge during a BG draw (or vice versa) is recorded pending and served after the current DONE; at most one pending per type.
REQ-018 RUN: column/row counters scan row-major, col 0..SPRITE_W-1 then row++, one pixel address per cycle.
REQ-019 char_addr = row*SPRITE_W+col; bg_addr = (Y+row)*320 + (X+col), computed as (y<<8)+(y<<6)+x, truncated to 17 bits.
REQ-020 Pipeline: x, y, valid registered alongside the ROM read; vga_colour driven from the ROM data the following cycle.
REQ-021 Timing: start edge k; plot high cycles k+1..k+N (N=SPRITE_W*SPRITE_H); FLUSH at k+N; done pulse during cycle k+N+1; IDLE or next pending run after.
REQ-022 Clipping: pixels with screen x >= 320 or y >= 240 keep their slot but plot=0; X+col computed 10 bits, Y+row 9 bits, no wrap.
REQ-023 Dropping a request mid-draw does not abort; done still pulses.
REQ-024 doneBG only after a BG draw, doneChar only after a char draw; never both in one cycle.
REQ-025 plot=0 and addresses hold 0 in IDLE and DONE.

Reset
REQ-026 resetn low at any time (including mid-draw): state IDLE, counters 0, pending flags cleared, edge-detect registers 0, plot/doneBG/doneChar/busy 0, vga_x/vga_y/vga_colour/char_addr/bg_addr 0; a request held high through reset release starts a draw on the first sampled cycle.

Configuration
REQ-027 Macro SPRITE_TRANSPARENCY_EN: defined -> char pixels equal to TRANSPARENT_COLOUR give plot=0 (slot still consumed, timing unchanged); undefined -> every in-bounds char pixel plotted; BG draws never keyed either way.

Verification
REQ-028 Reset, drawBG rises at (95,221), 8x8 -> 64 plots at x 95..102, y 221..228, bg_addr first 70815, doneBG once at start+65.
REQ-029 drawBG and drawChar rise together at (10,10) -> 64 BG plots, doneBG, then 64 char plots, doneChar; no overlap, no second BG.
REQ-030 drawChar at (316,236) -> only 16 pixels (x 316..319, y 236..239) plotted; doneChar still at start+65.
REQ-031 drawChar held high 200 cycles -> exactly one draw and one doneChar.
REQ-032 resetn pulsed low at pixel 30 of a BG draw -> plot 0 immediately, no doneBG; new drawBG edge restarts from pixel 0.
REQ-033 SPRITE_TRANSPARENCY_EN defined, char ROM all 9'h1FF except address 0 = 9'h007 -> single plot at (X,Y) colour 9'h007; undefined -> 64 plots.
